// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decoder with valid/ready handshake and optional skid buffer.
package decoder_pkg;
  typedef enum logic [1:0] {ALU_A_RS1, ALU_A_PC, ALU_A_ZERO} alu_a_sel_t;
  typedef enum logic {ALU_B_RS2, ALU_B_IMM_EXT} alu_b_sel_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND} alu_op_t;
  typedef enum logic [2:0] {BR_EQ = 3'd0, BR_NE = 3'd1, BR_LT = 3'd4, BR_GE = 3'd5, BR_LTU = 3'd6, BR_GEU = 3'd7} branch_op_t;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC_PLUS_4, WB_CSR} wb_mux_sel_t;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
    OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
    OP_IMM = 7'b0010011, OP_OP = 7'b0110011, OP_FENCE = 7'b0001111, OP_SYSTEM = 7'b1110011;
endpackage

module decode_stage import decoder_pkg::*; #(
  parameter int XLEN = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SKID = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [31:0]           i_in_instr,
  input  logic [XLEN-1:0]       i_in_pc,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [XLEN-1:0]       o_out_pc,
  output logic [REG_ADDR_W-1:0] o_rs1,
  output logic [REG_ADDR_W-1:0] o_rs2,
  output logic [REG_ADDR_W-1:0] o_rd,
  output logic [XLEN-1:0]       o_imm,
  output alu_a_sel_t            o_alu_a_mux_sel,
  output alu_b_sel_t            o_alu_b_mux_sel,
  output alu_op_t               o_alu_op,
  output branch_op_t            o_branch_op,
  output wb_mux_sel_t           o_wb_mux_sel,
  output logic                  o_sub_arith,
  output logic                  o_branch_instr,
  output logic                  o_branch_always,
  output logic                  o_csr_enable,
  output logic                  o_wb_write_enable,
  output logic                  o_dmem_read_enable,
  output logic                  o_dmem_write_enable,
  output logic [1:0]            o_dmem_width,
  output logic                  o_dmem_sign_ext,
  output logic                  o_illegal
);
  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rs1, rs2, rd;
    alu_a_sel_t            alu_a;
    alu_b_sel_t            alu_b;
    alu_op_t               alu_op;
    branch_op_t            br_op;
    wb_mux_sel_t           wb;
    logic                  sub_arith, br, br_always, csr, we, rd_en, wr_en;
    logic [1:0]            width;
    logic                  sign_ext, illegal;
  } dec_t;
  logic [31:0] w_ins, w_imm32;
  logic [6:0]  w_op, w_f7;
  logic [2:0]  w_f3;
  logic        w_use1, w_use2, w_use_rd, w_bad, w_stall, w_accept;
  dec_t        w_dec, r_out, r_skid;
  logic        r_out_valid, r_skid_valid;
  assign w_ins = i_in_instr;
  assign w_op  = w_ins[6:0];
  assign w_f3  = w_ins[14:12];
  assign w_f7  = w_ins[31:25];
  always_comb begin
    w_dec = '0;
    w_imm32 = {{20{w_ins[31]}}, w_ins[31:20]};
    {w_use1, w_use2, w_use_rd, w_bad} = '0;
    case (w_op)
      OP_LUI, OP_AUIPC: begin
        w_imm32 = {w_ins[31:12], 12'b0};
        w_dec.alu_a = w_op == OP_LUI ? ALU_A_ZERO : ALU_A_PC;
        w_dec.alu_b = ALU_B_IMM_EXT;
        {w_dec.we, w_use_rd} = 2'b11;
      end
      OP_JAL: begin
        w_imm32 = {{12{w_ins[31]}}, w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
        w_dec.alu_a = ALU_A_PC;
        w_dec.alu_b = ALU_B_IMM_EXT;
        w_dec.wb = WB_PC_PLUS_4;
        {w_dec.br_always, w_dec.we, w_use_rd} = 3'b111;
      end
      OP_JALR: begin
        w_dec.alu_b = ALU_B_IMM_EXT;
        w_dec.wb = WB_PC_PLUS_4;
        {w_dec.br_always, w_dec.we, w_use1, w_use_rd} = 4'b1111;
        w_bad = w_f3 != 3'd0;
      end
      OP_BRANCH: begin
        w_imm32 = {{20{w_ins[31]}}, w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
        w_dec.alu_a = ALU_A_PC;
        w_dec.alu_b = ALU_B_IMM_EXT;
        w_dec.br_op = branch_op_t'(w_f3);
        {w_dec.br, w_use1, w_use2} = 3'b111;
        w_bad = w_f3[2:1] == 2'b01;
      end
      OP_LOAD: begin
        w_dec.alu_b = ALU_B_IMM_EXT;
        w_dec.wb = WB_MEM;
        w_dec.width = w_f3[1:0];
        w_dec.sign_ext = !w_f3[2];
        {w_dec.rd_en, w_dec.we, w_use1, w_use_rd} = 4'b1111;
        w_bad = w_f3 == 3'd3 || w_f3[2:1] == 2'b11;
      end
      OP_STORE: begin
        w_imm32 = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
        w_dec.alu_b = ALU_B_IMM_EXT;
        w_dec.width = w_f3[1:0];
        {w_dec.wr_en, w_use1, w_use2} = 3'b111;
        w_bad = w_f3 > 3'd2;
      end
      OP_IMM: begin
        w_dec.alu_b = ALU_B_IMM_EXT;
        w_dec.alu_op = alu_op_t'(w_f3);
        w_dec.sub_arith = w_f3 == 3'd5 && w_f7[5];
        {w_dec.we, w_use1, w_use_rd} = 3'b111;
        w_bad = (w_f3 == 3'd1 && w_f7 != 7'h00) || (w_f3 == 3'd5 && w_f7 != 7'h00 && w_f7 != 7'h20);
      end
      OP_OP: begin
        w_dec.alu_op = alu_op_t'(w_f3);
        w_dec.sub_arith = w_f7[5];
        {w_dec.we, w_use1, w_use2, w_use_rd} = 4'b1111;
        w_bad = (w_f7 != 7'h00 && w_f7 != 7'h20) || (w_f7 == 7'h20 && w_f3 != 3'd0 && w_f3 != 3'd5);
      end
      OP_FENCE: ;
      OP_SYSTEM: begin
        w_dec.csr = w_f3 != 3'd0;
        w_dec.wb = w_dec.csr ? WB_CSR : WB_ALU;
        w_dec.we = w_dec.csr;
        w_use1 = w_dec.csr && !w_f3[2];
        w_use_rd = w_dec.csr;
      end
      default: w_bad = 1'b1;
    endcase
    w_dec.pc = i_in_pc;
    w_dec.imm = XLEN'($signed(w_imm32));
    w_dec.rs1 = REG_ADDR_W'(w_ins[19:15]);
    w_dec.rs2 = REG_ADDR_W'(w_ins[24:20]);
    w_dec.rd = REG_ADDR_W'(w_ins[11:7]);
    // Register indices beyond the configured file (e.g. x16+ on RV32E) are illegal.
    w_dec.illegal = w_bad || w_ins[1:0] != 2'b11 ||
      (w_use1 && (w_ins[19:15] >> REG_ADDR_W) != 5'd0) ||
      (w_use2 && (w_ins[24:20] >> REG_ADDR_W) != 5'd0) ||
      (w_use_rd && (w_ins[11:7] >> REG_ADDR_W) != 5'd0);
    if (w_dec.illegal) {w_dec.we, w_dec.br, w_dec.br_always, w_dec.rd_en, w_dec.wr_en, w_dec.csr} = '0;
  end
  assign w_stall = r_out_valid && !i_out_ready;
  assign o_in_ready = SKID != 0 ? !r_skid_valid : !w_stall;
  assign w_accept = i_in_valid && o_in_ready;
  // The skid entry only fills while the output is stalled and drains ahead of new input.
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_out <= '0;
      r_skid <= '0;
      r_out_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (i_flush) begin
      r_out_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_stall) begin
      if (w_accept) begin
        r_skid <= w_dec;
        r_skid_valid <= 1'b1;
      end
    end else if (r_skid_valid) begin
      r_out <= r_skid;
      r_out_valid <= 1'b1;
      r_skid_valid <= 1'b0;
    end else begin
      r_out_valid <= w_accept;
      if (w_accept) r_out <= w_dec;
    end
  assign o_out_valid = r_out_valid;
  assign o_out_pc = r_out.pc;
  assign o_rs1 = r_out.rs1;
  assign o_rs2 = r_out.rs2;
  assign o_rd = r_out.rd;
  assign o_imm = r_out.imm;
  assign o_alu_a_mux_sel = r_out.alu_a;
  assign o_alu_b_mux_sel = r_out.alu_b;
  assign o_alu_op = r_out.alu_op;
  assign o_branch_op = r_out.br_op;
  assign o_wb_mux_sel = r_out.wb;
  assign o_sub_arith = r_out.sub_arith;
  assign o_branch_instr = r_out.br;
  assign o_branch_always = r_out.br_always;
  assign o_csr_enable = r_out.csr;
  assign o_wb_write_enable = r_out.we;
  assign o_dmem_read_enable = r_out.rd_en;
  assign o_dmem_write_enable = r_out.wr_en;
  assign o_dmem_width = r_out.width;
  assign o_dmem_sign_ext = r_out.sign_ext;
  assign o_illegal = r_out.illegal;
endmodule
